// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - issue-stage bus: decode input, writeback and ALU output handshakes
interface alu_issue_stage_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int OP_W   = 3
) ();

  // Upstream decode side
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_opcode;
  logic [REG_AW-1:0] in_rs_a;
  logic [REG_AW-1:0] in_rs_b;
  logic              in_use_imm;
  logic [DATA_W-1:0] in_imm;

  // Writeback from the downstream stage
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  // ALU-facing side
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_input_a;
  logic [DATA_W-1:0] alu_input_b;
  logic [OP_W-1:0]   alu_opcode;

  // Stage side: consumes instructions and writeback, produces ALU inputs
  modport slave (
    input  in_valid, in_opcode, in_rs_a, in_rs_b, in_use_imm, in_imm,
    output in_ready,
    input  wb_en, wb_addr, wb_data,
    output out_valid, alu_input_a, alu_input_b, alu_opcode,
    input  out_ready
  );

  // Environment side: decode, writeback and ALU sink
  modport master (
    output in_valid, in_opcode, in_rs_a, in_rs_b, in_use_imm, in_imm,
    input  in_ready,
    output wb_en, wb_addr, wb_data,
    input  out_valid, alu_input_a, alu_input_b, alu_opcode,
    output out_ready
  );

endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - operand fetch/issue stage with register file and two-entry elastic buffer (optional OPERAND_BYPASS_EN)
module alu_issue_stage #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = 3,
  parameter int OP_W     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_issue_stage_if.slave    bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] rf_q [NUM_REGS];

  logic [DATA_W-1:0] out_a_q;
  logic [DATA_W-1:0] out_b_q;
  logic [OP_W-1:0]   out_op_q;
  logic [DATA_W-1:0] skid_a_q;
  logic [DATA_W-1:0] skid_b_q;
  logic [OP_W-1:0]   skid_op_q;

  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] opnd_a_d;
  logic [DATA_W-1:0] opnd_b_d;

  // Ready comes only from registered state; held low while in reset
  assign bus.in_ready    = rst_n && (state_q != S_FULL);
  assign bus.out_valid   = (state_q != S_EMPTY);
  assign bus.alu_input_a = out_a_q;
  assign bus.alu_input_b = out_b_q;
  assign bus.alu_opcode  = out_op_q;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  // Operand selection: register read, optional same-cycle writeback forwarding, immediate for B
  always_comb begin
    opnd_a_d = rf_q[bus.in_rs_a];
    opnd_b_d = rf_q[bus.in_rs_b];
`ifdef OPERAND_BYPASS_EN
    if (bus.wb_en && (bus.wb_addr == bus.in_rs_a)) begin
      opnd_a_d = bus.wb_data;
    end
    if (bus.wb_en && (bus.wb_addr == bus.in_rs_b)) begin
      opnd_b_d = bus.wb_data;
    end
`endif
    if (bus.in_use_imm) begin
      opnd_b_d = bus.in_imm;
    end
  end

  // Architectural register file, written by the downstream writeback port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (bus.wb_en) begin
      rf_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Elastic buffer FSM: OUT drives the ALU, SKID absorbs one entry under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      out_a_q   <= '0;
      out_b_q   <= '0;
      out_op_q  <= '0;
      skid_a_q  <= '0;
      skid_b_q  <= '0;
      skid_op_q <= '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            out_a_q  <= opnd_a_d;
            out_b_q  <= opnd_b_d;
            out_op_q <= bus.in_opcode;
            state_q  <= S_ONE;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            out_a_q  <= opnd_a_d;
            out_b_q  <= opnd_b_d;
            out_op_q <= bus.in_opcode;
          end else if (in_fire) begin
            skid_a_q  <= opnd_a_d;
            skid_b_q  <= opnd_b_d;
            skid_op_q <= bus.in_opcode;
            state_q   <= S_FULL;
          end else if (out_fire) begin
            state_q <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            out_a_q  <= skid_a_q;
            out_b_q  <= skid_b_q;
            out_op_q <= skid_op_q;
            state_q  <= S_ONE;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed and randomized checks of alu_issue_stage against a queue model
module tb_alu_issue_stage;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } ent_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ent_t       q[$];
  ent_t       last;
  logic [7:0] rf [8];

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last = '{a: 8'h00, b: 8'h00, op: 3'd0};
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
    chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, (rst_n === 1'b1) && (q.size() < 2)});
    chk({tag, ".a"}, {24'd0, bus.alu_input_a}, {24'd0, last.a});
    chk({tag, ".b"}, {24'd0, bus.alu_input_b}, {24'd0, last.b});
    chk({tag, ".op"}, {29'd0, bus.alu_opcode}, {29'd0, last.op});
  endtask

  // One clock: decide transfers from model occupancy and current inputs, then compare after the edge
  task automatic tick(input string tag);
    bit   inf;
    bit   outf;
    ent_t e;
    inf  = bus.in_valid && (q.size() < 2);
    outf = (q.size() > 0) && bus.out_ready;
    e.a  = rf[bus.in_rs_a];
    e.b  = bus.in_use_imm ? bus.in_imm : rf[bus.in_rs_b];
    e.op = bus.in_opcode;
`ifdef OPERAND_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == bus.in_rs_a) e.a = bus.wb_data;
    if (bus.wb_en && !bus.in_use_imm && bus.wb_addr == bus.in_rs_b) e.b = bus.wb_data;
`endif
    @(posedge clk);
    #1;
    if (outf) void'(q.pop_front());
    if (inf) q.push_back(e);
    if (bus.wb_en) rf[bus.wb_addr] = bus.wb_data;
    if (q.size() > 0) last = q[0];
    check_all(tag);
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.in_use_imm = 1'b0;
    bus.wb_en      = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                       input logic ui, input logic [7:0] imm);
    bus.in_valid   = 1'b1;
    bus.in_opcode  = op;
    bus.in_rs_a    = ra;
    bus.in_rs_b    = rb;
    bus.in_use_imm = ui;
    bus.in_imm     = imm;
  endtask

  task automatic wb(input logic [2:0] addr, input logic [7:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
  endtask

  initial begin
    logic [2:0] ops [4];
    logic [7:0] byp_exp;
    checks   = 0;
    failures = 0;
    ops[0] = 3'b001; ops[1] = 3'b011; ops[2] = 3'b101; ops[3] = 3'b111;

    idle();
    bus.in_opcode = 3'd0; bus.in_rs_a = 3'd0; bus.in_rs_b = 3'd0; bus.in_imm = 8'h00;
    bus.wb_addr = 3'd0; bus.wb_data = 8'h00; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check_all("reset");

    // Reset while an instruction is held at the outputs
    wb(3'd5, 8'hFF);
    tick("rst_wb");
    idle();
    bus.out_ready = 1'b0;
    issue(3'b110, 3'd5, 3'd5, 1'b0, 8'h00);
    tick("rst_issue");
    chk("rst_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    idle();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("rst_async");
    chk("rst_a_zero", {24'd0, bus.alu_input_a}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check_all("rst_release");
    bus.out_ready = 1'b1;
    issue(3'b000, 3'd5, 3'd0, 1'b0, 8'h00);
    tick("rst_r5");
    chk("rst_r5_a", {24'd0, bus.alu_input_a}, 32'h00);
    idle();
    tick("rst_drain");

    // Basic issue
    wb(3'd3, 8'h5A);
    tick("basic_wb");
    idle();
    issue(3'b001, 3'd3, 3'd3, 1'b0, 8'h00);
    tick("basic_issue");
    chk("basic_a", {24'd0, bus.alu_input_a}, 32'h5A);
    chk("basic_b", {24'd0, bus.alu_input_b}, 32'h5A);
    chk("basic_op", {29'd0, bus.alu_opcode}, 32'd1);
    idle();
    tick("basic_after");
    chk("basic_valid_drop", {31'd0, bus.out_valid}, 32'd0);

    // Immediate replaces operand B
    issue(3'b100, 3'd3, 3'd0, 1'b1, 8'h02);
    tick("imm_issue");
    chk("imm_b", {24'd0, bus.alu_input_b}, 32'h02);
    idle();
    tick("imm_after");

    // Backpressure: two entries fill, third held off until drain
    bus.out_ready = 1'b0;
    issue(3'b000, 3'd1, 3'd2, 1'b0, 8'h00);
    tick("bp_i1");
    issue(3'b010, 3'd3, 3'd4, 1'b0, 8'h00);
    tick("bp_i2");
    chk("bp_full", {31'd0, bus.in_ready}, 32'd0);
    issue(3'b101, 3'd3, 3'd0, 1'b1, 8'h77);
    tick("bp_i3_hold0");
    tick("bp_i3_hold1");
    chk("bp_hold_op", {29'd0, bus.alu_opcode}, 32'd0);
    bus.out_ready = 1'b1;
    tick("bp_drain1");
    chk("bp_drain1_op", {29'd0, bus.alu_opcode}, 32'd2);
    chk("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
    tick("bp_drain2");
    chk("bp_drain2_op", {29'd0, bus.alu_opcode}, 32'd5);
    idle();
    tick("bp_drain3");

    // Same-cycle writeback and read
    wb(3'd2, 8'h00);
    tick("byp_clear");
    wb(3'd2, 8'h33);
    issue(3'b011, 3'd2, 3'd0, 1'b1, 8'h00);
    tick("byp_issue");
`ifdef OPERAND_BYPASS_EN
    byp_exp = 8'h33;
`else
    byp_exp = 8'h00;
`endif
    chk("byp_a", {24'd0, bus.alu_input_a}, {24'd0, byp_exp});
    idle();
    issue(3'b011, 3'd2, 3'd0, 1'b1, 8'h00);
    tick("byp_reread");
    chk("byp_reread_a", {24'd0, bus.alu_input_a}, 32'h33);
    idle();
    tick("byp_after");

    // Streaming at full rate
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 3'(i), 3'(i + 1), 1'b0, 8'h00);
      tick("stream");
      chk("stream_op", {29'd0, bus.alu_opcode}, {29'd0, ops[i]});
    end
    idle();
    tick("stream_end");

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.in_opcode  = 3'($urandom);
      bus.in_rs_a    = 3'($urandom);
      bus.in_rs_b    = 3'($urandom);
      bus.in_use_imm = ($urandom_range(0, 3) == 0);
      bus.in_imm     = 8'($urandom);
      bus.wb_en      = ($urandom_range(0, 2) == 0);
      bus.wb_addr    = 3'($urandom);
      bus.wb_data    = 8'($urandom);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-fetch/issue stage directly upstream of the 8-bit ALU.
- Holds the architectural register file (8 x 8 bits) and reads two source operands, with an optional immediate replacing operand B.
- Registers the operands and the 3-bit opcode into a two-entry elastic buffer with valid/ready handshakes.
- Drives the ALU inputs with a fixed 1-cycle latency and accepts writeback from the downstream stage.

Parameters:
DATA_W, 8, operand/register width (matches ALU operand width)
NUM_REGS, 8, number of architectural registers
REG_AW, 3, register address width, equal to clog2(NUM_REGS)
OP_W, 3, ALU opcode width

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream decode presents an instruction
in_ready  output  1  stage can accept an instruction this cycle
in_opcode  input  OP_W  ALU opcode to issue
in_rs_a  input  REG_AW  source register for operand A
in_rs_b  input  REG_AW  source register for operand B
in_use_imm  input  1  1: operand B = in_imm; 0: operand B = reg[in_rs_b]
in_imm  input  DATA_W  immediate value
wb_en  input  1  writeback enable
wb_addr  input  REG_AW  writeback destination register
wb_data  input  DATA_W  writeback value
out_valid  output  1  ALU inputs below are valid
out_ready  input  1  downstream consumed current ALU inputs
alu_input_a  output  DATA_W  operand A to ALU
alu_input_b  output  DATA_W  operand B to ALU
alu_opcode  output  OP_W  opcode to ALU

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers cleared to 0x00.
  - State is EMPTY; out_valid=0.
  - alu_input_a, alu_input_b and alu_opcode cleared to 0.
  - in_ready forced 0 while rst_n is low.
  - An in-flight instruction is discarded.
- Register file:
  - Write on rising edge when wb_en=1.
  - Reads are combinational, indexed by in_rs_a and in_rs_b.
- Acceptance: a transfer is accepted when in_valid & in_ready at a rising edge ("in_fire").
  - Operands are captured at acceptance and frozen.
  - A later writeback does not alter buffered entries.
  - Avoiding RAW hazards on buffered entries is the producer's responsibility.
- Output transfer: "out_fire" = out_valid & out_ready.
- Latency: the instruction accepted at edge N appears on the outputs after edge N, with out_valid=1 in cycle N+1 when the buffer was EMPTY.
- State machine (entries: OUT register, SKID register):
  - EMPTY: in_fire -> ONE, OUT loaded.
  - ONE:
    - in_fire & out_fire -> ONE, OUT replaced.
    - in_fire & !out_fire -> FULL, new instruction to SKID.
    - !in_fire & out_fire -> EMPTY.
    - neither -> ONE, hold.
  - FULL: in_ready=0; out_fire -> ONE, SKID moves to OUT; else hold.
- in_ready = (state != FULL), decoded from registered state only. There is no combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY).
- While out_valid=1 and out_ready=0, alu_input_a, alu_input_b and alu_opcode are stable.
- While out_valid=0, outputs hold their last values.
- Ordering: strict FIFO; no drop, no duplication.
- Throughput: one instruction per cycle while out_ready is held 1.
- No arithmetic is performed; widths pass through unchanged.
- Opcode values 0-7 are all legal and passed through unchanged.
- Writeback and read of the same register in the same cycle: the result depends on the macro below.
- Writeback when in_fire=0: the register updates with no other effect.

Optional Feature:
- Macro: OPERAND_BYPASS_EN.
- Defined: when wb_en=1 and wb_addr equals in_rs_a (or in_rs_b with in_use_imm=0) in the accepting cycle, wb_data is captured in place of the stale register value. This is write-through forwarding.
- Undefined: reads return the pre-write register value (read-before-write). The register still updates at that edge.

Test Plan:
- Reset: write r5=0xFF, assert rst_n=0 for 2 cycles while out_valid=1 -> out_valid=0 and all outputs 0 immediately. After release, in_ready=1 and issuing rs_a=5 yields alu_input_a=0x00.
- Basic issue: wb r3=0x5A; next cycle issue opcode=3'b001, rs_a=3, rs_b=3, out_ready=1 -> one cycle later out_valid=1, a=0x5A, b=0x5A, opcode=001; out_valid=0 the following cycle.
- Immediate: r3=0x5A; issue opcode=3'b100, rs_a=3, use_imm=1, imm=0x02 -> a=0x5A, b=0x02, opcode=100.
- Backpressure: out_ready=0; issue I1 (opcode 000) and I2 (opcode 010) back-to-back -> in_ready=0 after I2; I3 held on the inputs is not accepted. Then raise out_ready -> outputs I1, I2, I3 in order, one per cycle; in_ready returns to 1 the cycle after the first drain.
- Bypass: r2=0x00; in the same cycle drive wb_en=1, wb_addr=2, wb_data=0x33 and issue rs_a=2 -> a=0x33 with OPERAND_BYPASS_EN, a=0x00 without it. A subsequent issue reads 0x33 in both builds.
- Streaming: out_ready=1; issue 4 back-to-back instructions (opcodes 001, 011, 101, 111) -> out_valid high 4 consecutive cycles with matching opcodes; in_ready never drops.
